// File: rtl/tetris_param.sv
// Parameterised falling-block board: drops one piece per transaction, clears full rows,
// and reports the running score, overflow and the final board at the end of each round.
module tetris_param #(
  parameter int COLS     = 6,
  parameter int ROWS     = 12,
  parameter int N_PIECES = 16,
  parameter int SCORE_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [2:0]                tetrominoes,
  input  logic [$clog2(COLS)-1:0]   position,
  output logic                      in_ready,
  output logic                      score_valid,
  output logic                      fail,
  output logic [SCORE_W-1:0]        score,
  output logic                      tetris_valid,
  output logic [ROWS*COLS-1:0]      tetris
);

  localparam int PW = $clog2(COLS);
  localparam int NR = ROWS + 4;
  localparam int CW = $clog2(N_PIECES + 1);

  typedef enum logic [1:0] {IDLE, DROP, CLEAR, REPORT} state_t;

  // Four cells packed as {y,x} nibbles, 2 bits each, cell 0 in the low nibble.
  function automatic logic [15:0] shape_cells(input logic [2:0] s);
    case (s)
      3'd0: shape_cells = 16'h5410;
      3'd1: shape_cells = 16'hC840;
      3'd2: shape_cells = 16'h3210;
      3'd3: shape_cells = 16'h9518;
      3'd4: shape_cells = 16'h6540;
      3'd5: shape_cells = 16'h8410;
      3'd6: shape_cells = 16'h6510;
      default: shape_cells = 16'h8541;
    endcase
  endfunction

  function automatic int shape_width(input logic [2:0] s);
    case (s)
      3'd1:       shape_width = 1;
      3'd2:       shape_width = 4;
      3'd4, 3'd6: shape_width = 3;
      default:    shape_width = 2;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [COLS-1:0]      board_q [NR];
  logic [COLS-1:0]      board_d [NR];
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           shape_q, shape_d;
  logic [PW-1:0]        col_q, col_d;

  logic        accept, full_found, over, round_end;
  int          full_idx, land_row, clamp_w, clamp_col;
  int          col_h [COLS];
  logic [15:0] cells;

  assign accept    = (state_q == IDLE) && in_valid;
  assign round_end = (state_q == REPORT) && (over || (cnt_q == CW'(N_PIECES)));

  // Vertical drop: the piece rests on the highest obstruction under any of its cells.
  always_comb begin
    cells    = shape_cells(shape_q);
    land_row = 0;
    for (int c = 0; c < COLS; c++) begin
      col_h[c] = 0;
      for (int r = 0; r < NR; r++)
        if (board_q[r][c]) col_h[c] = r + 1;
    end
    for (int i = 0; i < 4; i++)
      if (col_h[int'(col_q) + int'(cells[4*i +: 2])] - int'(cells[4*i+2 +: 2]) > land_row)
        land_row = col_h[int'(col_q) + int'(cells[4*i +: 2])] - int'(cells[4*i+2 +: 2]);
  end

  always_comb begin
    full_found = 1'b0;
    full_idx   = 0;
    over       = 1'b0;
    for (int r = NR - 1; r >= 0; r--)
      if (&board_q[r]) begin
        full_found = 1'b1;
        full_idx   = r;
      end
    for (int r = ROWS; r < NR; r++)
      over = over | (|board_q[r]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DROP;
      DROP:    state_d = CLEAR;
      CLEAR:   if (!full_found) state_d = REPORT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    board_d   = board_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    shape_d   = shape_q;
    col_d     = col_q;
    clamp_w   = shape_width(tetrominoes);
    clamp_col = (int'(position) + clamp_w > COLS) ? COLS - clamp_w : int'(position);
    if (accept) begin
      shape_d = tetrominoes;
      col_d   = PW'(clamp_col);
      cnt_d   = cnt_q + CW'(1);
    end
    case (state_q)
      DROP:
        for (int i = 0; i < 4; i++)
          board_d[land_row + int'(cells[4*i+2 +: 2])][int'(col_q) + int'(cells[4*i +: 2])] = 1'b1;
      CLEAR:
        if (full_found) begin
          for (int r = 0; r < NR - 1; r++)
            if (r >= full_idx) board_d[r] = board_q[r+1];
          board_d[NR-1] = '0;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end
      REPORT:
        if (round_end) begin
          board_d = '{default: '0};
          score_d = '0;
          cnt_d   = '0;
        end
      default: ;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == IDLE);
    score_valid  = 1'b0;
    fail         = 1'b0;
    score        = '0;
    tetris_valid = 1'b0;
    tetris       = '0;
    if (state_q == REPORT) begin
      score_valid  = 1'b1;
      fail         = over;
      score        = score_q;
      tetris_valid = round_end;
      if (round_end)
        for (int r = 0; r < ROWS; r++) tetris[r*COLS +: COLS] = board_q[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      board_q <= '{default: '0};
      score_q <= '0;
      cnt_q   <= '0;
      shape_q <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      shape_q <= shape_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: doc/tetris_param.md
TETRIS_PARAM -- requirements
Module: tetris_param

Interface
REQ-001 The module SHALL have parameter COLS, default 6, meaning board width in columns (legal range 4..16).
REQ-002 The module SHALL have parameter ROWS, default 12, meaning visible board height in rows (legal range 4..32).
REQ-003 The module SHALL have parameter N_PIECES, default 16, meaning pieces per round.
REQ-004 The module SHALL have parameter SCORE_W, default 4, meaning score width in bits.
REQ-005 Derived width: PW = clog2(COLS).
REQ-006 The module SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1: the single clock; all state is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: piece offered.
- tetrominoes, input, 3: shape code 0..7.
- position, input, PW: leftmost column of the piece.
- in_ready, output, 1: block can accept a piece.
- score_valid, output, 1: one-cycle result strobe.
- fail, output, 1: overflow occurred; valid with score_valid.
- score, output, SCORE_W: current round score; valid with score_valid.
- tetris_valid, output, 1: round-end strobe.
- tetris, output, ROWS*COLS: final board; bit r*COLS+c, where row 0 is the bottom and column 0 is the left.

Function
REQ-007 The shape cell lists SHALL be (x,y), relative to the bottom-left anchor:
- 0: (0,0)(1,0)(0,1)(1,1)
- 1: (0,0)(0,1)(0,2)(0,3)
- 2: (0,0)(1,0)(2,0)(3,0)
- 3: (0,2)(1,0)(1,1)(1,2)
- 4: (0,0)(0,1)(1,1)(2,1)
- 5: (0,0)(1,0)(0,1)(0,2)
- 6: (0,0)(1,0)(1,1)(2,1)
- 7: (1,0)(0,1)(1,1)(0,2)
REQ-008 A piece SHALL be accepted on a rising edge only when in_valid=1 and in_ready=1; when in_ready=0, in_valid SHALL be ignored.
REQ-009 If position + shape width > COLS, the anchor column SHALL be clamped to COLS - shape width; no error is flagged.
REQ-010 The internal board SHALL hold ROWS+4 rows, so that every overflowing placement is representable.
REQ-011 The FSM states SHALL be IDLE, DROP, CLEAR and REPORT, with transitions:
- IDLE to DROP on accept.
- DROP to CLEAR after 1 cycle.
- CLEAR stays in CLEAR while any full row exists, otherwise goes to REPORT.
- REPORT to IDLE after 1 cycle.
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 DROP SHALL place the piece at the lowest anchor row at which no piece cell overlaps an occupied cell and every cell lies at y >= 0, i.e. a straight vertical drop.
REQ-014 Each CLEAR cycle that finds a full row (rows 0..ROWS+3 considered) SHALL remove the lowest full row, shift all rows above it down by one, and fill the top row with 0.
REQ-015 Each removed row SHALL add 1 to score, saturating at 2^SCORE_W - 1.
REQ-016 Latency: with the accept cycle numbered 0 and k rows removed, score_valid SHALL be 1 in cycle k+3 only.
REQ-017 Fail SHALL be set in REPORT if any cell in rows ROWS..ROWS+3 is occupied after clearing.
REQ-018 Round end SHALL occur when fail=1 or the accepted-piece counter reaches N_PIECES.
- On round end, tetris_valid=1 in the same cycle as score_valid, and tetris = rows 0..ROWS-1 of the board.
- On the following edge, the board, score and piece counter SHALL be cleared.
REQ-019 Outside REPORT, score_valid, tetris_valid and fail SHALL be 0, and score and tetris SHALL be all-zero.
REQ-020 The piece counter SHALL be wide enough for N_PIECES and SHALL never wrap within a round.
REQ-021 Any pieces offered after a fail SHALL start a new round from an empty board.

Reset
REQ-022 rst=1 SHALL immediately force the following, including mid-DROP or mid-CLEAR:
- state IDLE, board empty, score 0, counter 0.
- score_valid=0, tetris_valid=0, fail=0, score=0, tetris=0.
- in_ready=1.
REQ-023 After rst falls, the first accepted piece SHALL begin a fresh round.

Verification
REQ-024 The bench SHALL cover at least the following directed scenarios, with COLS=6, ROWS=12, N_PIECES=16 and SCORE_W=4:
- Reset; shape 0 at position 0 -> in_ready=0 in cycles 1..3; score_valid=1 in cycle 3 with score=0, fail=0, tetris_valid=0.
- Shape 2 at position 0, then shape 0 at position 4 -> second result in cycle 4 (k=1) with score=1; board bits 4 and 5 set, all other bits 0.
- Shape 1 at position 0, four times -> 4th result has fail=1 and tetris_valid=1; tetris bits 0, 6, 12, ..., 66 set; the next piece starts on an empty board with score 0.
- 16 pieces of shape 0 at positions 0,2,4,0,2,4,... -> every third piece has k=2; the 16th result has tetris_valid=1, score=10, fail=0, and tetris bits 0, 1, 6, 7 set.
- Shape 2 at position 5 -> clamped to anchor column 2; board bits 2..5 set.
- rst pulsed during a CLEAR cycle -> all outputs 0 within the same cycle, in_ready=1; the next piece reports score=0.
